// File: rtl/mul8_pkg.sv
// Shared constants and state encoding for the sequential 8x8 multiplier.
//   MUL_W    - operand width (fixed by the shared cla adder)
//   CNT_W    - iteration counter width
//   MUL_ITER - number of shift-and-add iterations per multiply
package mul8_pkg;

    localparam int MUL_W    = 8;
    localparam int CNT_W    = 3;
    localparam int MUL_ITER = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/cla.sv
// 8-bit adder with generate/propagate carry chain.
// Ports:
//   a, b     - addends
//   cin      - carry in
//   sum      - low 8 bits of a + b + cin
//   cout     - carry out of bit 7
//   overflow - signed overflow (carry into bit 7 xor carry out)
module cla (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       overflow
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c[0] = cin;
        for (int unsigned i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum      = p ^ c[7:0];
    assign cout     = c[8];
    assign overflow = c[8] ^ c[7];

endmodule

// File: rtl/mul8_seq.sv
// Multi-cycle unsigned 8x8 -> 16-bit shift-and-add multiplier.
// One cla adder is reused over eight iterations, one per clock.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   start   - request; accepted in IDLE or DONE
//   a, b    - multiplicand / multiplier, sampled on acceptance
//   product - {acc_hi, acc_lo}; meaningful from DONE until next accepted start
//   busy    - high while iterating
//   done    - one-cycle completion pulse
module mul8_seq
    import mul8_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MUL_W-1:0]   a,
    input  logic [MUL_W-1:0]   b,
    output logic [2*MUL_W-1:0] product,
    output logic               busy,
    output logic               done
);

    mul_state_t       state, state_next;
    logic [MUL_W-1:0] mcand, mcand_next;
    logic [MUL_W-1:0] acc_hi, acc_hi_next;
    logic [MUL_W-1:0] acc_lo, acc_lo_next;
    logic [CNT_W-1:0] count, count_next;

    logic [MUL_W-1:0] addend;
    logic [MUL_W-1:0] sum;
    logic             cout;
    logic             overflow_unused;

    // Add the multiplicand only when the current multiplier bit is set.
    assign addend = mcand & {MUL_W{acc_lo[0]}};

    cla u_cla (
        .a        (acc_hi),
        .b        (addend),
        .cin      (1'b0),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow_unused)
    );

    assign product = {acc_hi, acc_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
        end else begin
            state  <= state_next;
            mcand  <= mcand_next;
            acc_hi <= acc_hi_next;
            acc_lo <= acc_lo_next;
            count  <= count_next;
        end
    end

    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        acc_hi_next = acc_hi;
        acc_lo_next = acc_lo;
        count_next  = count;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mcand_next  = a;
                    acc_hi_next = '0;
                    acc_lo_next = b;
                    count_next  = '0;
                    state_next  = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                // cout is the 9th sum bit; it shifts into acc_hi[7].
                acc_hi_next = {cout, sum[MUL_W-1:1]};
                acc_lo_next = {sum[0], acc_lo[MUL_W-1:1]};
                count_next  = count + 1'b1;
                if (count == CNT_W'(MUL_ITER - 1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    mcand_next  = a;
                    acc_hi_next = '0;
                    acc_lo_next = b;
                    count_next  = '0;
                    state_next  = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul8_seq.sv
// Directed testbench for mul8_seq.
module tb_mul8_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    mul8_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one multiply and follow it to DONE and back to IDLE.
    task automatic run_mul(input logic [7:0] ma, input logic [7:0] mb, input logic [15:0] exp);
        start = 1'b1;
        a     = ma;
        b     = mb;
        tick();
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check_eq("run_busy", {15'd0, busy}, 16'd1);
            check_eq("run_done", {15'd0, done}, 16'd0);
            tick();
        end
        check_eq("done_pulse", {15'd0, done}, 16'd1);
        check_eq("done_busy", {15'd0, busy}, 16'd0);
        check_eq("product", product, exp);
        tick();
        check_eq("idle_done", {15'd0, done}, 16'd0);
        check_eq("idle_busy", {15'd0, busy}, 16'd0);
        check_eq("product_hold", product, exp);
    endtask

    initial begin
        // Reset asserted between edges must act immediately.
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_product", product, 16'h0000);
        check_eq("rst_async_busy", {15'd0, busy}, 16'd0);
        check_eq("rst_async_done", {15'd0, done}, 16'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("idle_product", product, 16'h0000);
            check_eq("idle_busy", {15'd0, busy}, 16'd0);
            check_eq("idle_done", {15'd0, done}, 16'd0);
        end

        run_mul(8'h0D, 8'h0B, 16'h008F);
        run_mul(8'hFF, 8'hFF, 16'hFE01);
        run_mul(8'h5A, 8'h00, 16'h0000);
        run_mul(8'h00, 8'hA5, 16'h0000);
        run_mul(8'h01, 8'hFF, 16'h00FF);

        // Back-to-back: start held high straight through DONE.
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h10;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq("b2b1_busy", {15'd0, busy}, 16'd1);
            tick();
        end
        check_eq("b2b1_done", {15'd0, done}, 16'd1);
        check_eq("b2b1_product", product, 16'h0100);
        a = 8'h03;
        b = 8'h07;
        tick();
        start = 1'b0;
        check_eq("b2b2_no_idle", {15'd0, busy}, 16'd1);
        check_eq("b2b2_done_low", {15'd0, done}, 16'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_eq("b2b2_busy", {15'd0, busy}, 16'd1);
        end
        tick();
        check_eq("b2b2_done", {15'd0, done}, 16'd1);
        check_eq("b2b2_product", product, 16'h0015);
        tick();
        check_eq("b2b2_idle", {15'd0, done | busy}, 16'd0);

        // Start while busy is ignored.
        start = 1'b1;
        a     = 8'h02;
        b     = 8'h03;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq("intr_busy", {15'd0, busy}, 16'd1);
            check_eq("intr_done", {15'd0, done}, 16'd0);
            if (i == 3) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check_eq("intr_done_pulse", {15'd0, done}, 16'd1);
        check_eq("intr_product", product, 16'h0006);
        tick();
        check_eq("intr_idle", {15'd0, done | busy}, 16'd0);

        // Reset in the middle of a RUN.
        start = 1'b1;
        a     = 8'hC8;
        b     = 8'h64;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("mid_busy", {15'd0, busy}, 16'd1);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", {15'd0, busy}, 16'd0);
        check_eq("mid_rst_product", product, 16'h0000);
        check_eq("mid_rst_done", {15'd0, done}, 16'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("post_rst_done", {15'd0, done}, 16'd0);
            check_eq("post_rst_busy", {15'd0, busy}, 16'd0);
        end
        run_mul(8'hC8, 8'h64, 16'h4E20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
